shift_tx_sequencer: RTL and testbench
=====================================

SHIFT_TX_SEQUENCER -- requirements
Module: shift_tx_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the word width and the shift-register width it controls.
REQ-002 Parameter GAP_CYCLES, default 1, SHALL set the idle hold cycles after each word (0 allowed).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-low.
REQ-005 in_valid  input  1  upstream word available.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  word to serialize.
REQ-008 dir  input  1  0 = MSB-first (shift left), 1 = LSB-first (shift right); sampled at accept only.
REQ-009 sr_q  input  WIDTH  parallel output fed back from the controlled shift register.
REQ-010 select  output  2  shift-register command: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-011 p_din  output  WIDTH  parallel load data for the shift register.
REQ-012 s_left_din  output  1  fill bit for left shift; SHALL always be 0.
REQ-013 s_right_din  output  1  fill bit for right shift; SHALL always be 0.
REQ-014 ser_out  output  1  serial data bit.
REQ-015 ser_valid  output  1  ser_out carries a valid bit this cycle.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse at end of word.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, SHIFT, GAP, DONE.
REQ-019 IDLE: in_ready=1, select=00; in_valid=1 SHALL capture in_data and dir into registers and transition to LOAD on that edge.
REQ-020 LOAD (exactly 1 cycle): select=11, p_din=captured word, in_ready=0; next state SHIFT.
REQ-021 SHIFT (exactly WIDTH cycles): select=10 if captured dir=0 else 01; ser_valid=1.
REQ-022 ser_out SHALL be combinational from sr_q: sr_q[WIDTH-1] when dir=0, sr_q[0] when dir=1; 0 when ser_valid=0.
REQ-023 Bit counter SHALL be ceil(log2(WIDTH))+1 bits, clear on LOAD, increment each SHIFT cycle; leave SHIFT when count reaches WIDTH-1.
REQ-024 After SHIFT: to GAP if GAP_CYCLES>0 (held select=00 for GAP_CYCLES cycles via separate counter), else directly to DONE.
REQ-025 DONE (exactly 1 cycle): done=1, select=00, in_ready=0; next state IDLE.
REQ-026 Per-word latency: accept edge -> first ser_valid 2 cycles later; word occupies 1+WIDTH+GAP_CYCLES+1 cycles before in_ready returns.
REQ-027 in_valid while in_ready=0 SHALL be ignored; in_data/dir changes outside the accept cycle SHALL not affect the word in flight.
REQ-028 p_din SHALL output the captured word in all states (only consumed under select=11).
REQ-029 Back-to-back: in_valid held high SHALL be accepted on the first IDLE cycle after DONE, no extra bubble.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, counters 0, captured word 0, captured dir 0.
REQ-031 While rst=0: in_ready=0, select=00, p_din=0, ser_out=0, ser_valid=0, busy=0, done=0.
REQ-032 Reset mid-word SHALL abort the word with no done pulse; in_ready=1 on the first cycle after rst returns high.

Verification (bench connects a reference 4-bit universal shift register between select/p_din/fill outputs and sr_q)
REQ-033 WIDTH=4, GAP=1: accept 4'hA, dir=0 -> ser_out 1,0,1,0 on 4 consecutive ser_valid cycles, done 2 cycles after last bit.
REQ-034 Accept 4'hA, dir=1 -> ser_out 0,1,0,1; sr_q ends 4'h0; in_ready high 7 cycles after accept edge.
REQ-035 in_valid held high with 4'h3 then 4'hC -> serial stream 0,0,1,1,1,1,0,0 with exactly 1 gap + 1 done cycle between words.
REQ-036 Toggle in_data/dir during SHIFT of 4'h9 dir=0 -> output remains 1,0,0,1; in_ready stays 0.
REQ-037 Assert rst low during 2nd SHIFT cycle -> all outputs 0 at once, no done; after release, accept 4'h5 dir=0 -> 0,1,0,1.
REQ-038 GAP_CYCLES=0 instance: accept 4'hF -> done on cycle immediately after 4th bit.

Source files
------------

// File: rtl/shift_tx_sequencer.sv
// shift_tx_sequencer: serializes one WIDTH-bit word at a time by commanding an
// external universal shift register (select/p_din/fill bits) and reading its
// parallel output back (sr_q) to form ser_out.
// Latency: accept edge -> LOAD -> first ser_valid 2 cycles later. A word holds
// the block for 1+WIDTH+GAP_CYCLES+1 cycles before in_ready returns.
// Backpressure: in_ready is high only in IDLE. in_valid is ignored otherwise.
// Ports: clk, rst (async active-low), in_valid/in_ready/in_data/dir (word
// upstream), sr_q (shift register feedback), select/p_din/s_left_din/
// s_right_din (shift register command), ser_out/ser_valid, busy, done.
module shift_tx_sequencer #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             dir,
  input  logic [WIDTH-1:0] sr_q,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] p_din,
  output logic             s_left_din,
  output logic             s_right_din,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] word_q;
  logic             dir_q;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  // Only the end bits of sr_q feed ser_out; the rest is deliberately ignored.
  logic sr_q_unused;
  assign sr_q_unused = ^sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      word_q  <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q <= in_data;
            dir_q  <= dir;
            state  <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          bit_cnt <= bit_cnt + CW'(1);
          // The shift issued in the cycle with count WIDTH-1 is the last one.
          if (bit_cnt == CW'(WIDTH - 1)) begin
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? GAP : DONE;
          end
        end
        GAP: begin
          // Only reachable when GAP_CYCLES > 0, so the compare value is valid.
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= DONE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode of the state register. in_ready is qualified by rst so it is
  // low during reset yet high in the very first cycle after release.
  always_comb begin
    in_ready  = 1'b0;
    select    = 2'b00;
    ser_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        busy     = 1'b0;
      end
      LOAD: begin
        select = 2'b11;
      end
      SHIFT: begin
        select    = dir_q ? 2'b01 : 2'b10;
        ser_valid = 1'b1;
      end
      GAP: begin
        select = 2'b00;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign p_din       = word_q;
  assign s_left_din  = 1'b0;
  assign s_right_din = 1'b0;
  assign ser_out     = ser_valid & (dir_q ? sr_q[0] : sr_q[WIDTH-1]);

endmodule

// File: tb/tb_shift_tx_sequencer.sv
// tb_shift_tx_sequencer: two sequencer instances (GAP_CYCLES=1 and 0), each
// driving a behavioural 4-bit universal shift register whose output is fed
// back to sr_q. Expected per-cycle outputs come from a word-level timeline.
module tb_shift_tx_sequencer;

  typedef struct packed {
    logic       rdy;
    logic       busy;
    logic       sv;
    logic       so;
    logic       dn;
    logic [1:0] sel;
    logic [3:0] pd;
    logic       lf;
    logic       rf;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Instance 1: GAP_CYCLES = 1
  logic       v1, dr1, rdy1, lf1, rf1, so1, sv1, busy1, dn1;
  logic [3:0] d1, sr1, pd1;
  logic [1:0] sel1;
  // Instance 0: GAP_CYCLES = 0
  logic       v0, dr0, rdy0, lf0, rf0, so0, sv0, busy0, dn0;
  logic [3:0] d0, sr0, pd0;
  logic [1:0] sel0;

  shift_tx_sequencer #(.WIDTH(4), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .dir(dr1), .sr_q(sr1), .select(sel1), .p_din(pd1), .s_left_din(lf1),
    .s_right_din(rf1), .ser_out(so1), .ser_valid(sv1), .busy(busy1), .done(dn1)
  );

  shift_tx_sequencer #(.WIDTH(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .dir(dr0), .sr_q(sr0), .select(sel0), .p_din(pd0), .s_left_din(lf0),
    .s_right_din(rf0), .ser_out(so0), .ser_valid(sv0), .busy(busy0), .done(dn0)
  );

  // Reference universal shift registers: 00 hold, 01 right, 10 left, 11 load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr1 <= '0;
    else case (sel1)
      2'b01: sr1 <= {rf1, sr1[3:1]};
      2'b10: sr1 <= {sr1[2:0], lf1};
      2'b11: sr1 <= pd1;
      default: sr1 <= sr1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr0 <= '0;
    else case (sel0)
      2'b01: sr0 <= {rf0, sr0[3:1]};
      2'b10: sr0 <= {sr0[2:0], lf0};
      2'b11: sr0 <= pd0;
      default: sr0 <= sr0;
    endcase
  end

  obs_t o1, o0;
  assign o1 = {rdy1, busy1, sv1, so1, dn1, sel1, pd1, lf1, rf1};
  assign o0 = {rdy0, busy0, sv0, so0, dn0, sel0, pd0, lf0, rf0};

  // Word-level model: when idle and a word is offered, the whole timeline of
  // that word (load, WIDTH bits, gap cycles, done) is queued up front.
  obs_t       pq[2][$];
  logic [3:0] lw[2];

  function automatic obs_t mk(logic rdy, logic bsy, logic sv, logic so,
                              logic dn, logic [1:0] sel, logic [3:0] pd);
    obs_t r;
    r = {rdy, bsy, sv, so, dn, sel, pd, 1'b0, 1'b0};
    return r;
  endfunction

  function automatic obs_t model_step(int k, int gap, logic v, logic [3:0] d, logic dr);
    obs_t e;
    if (pq[k].size() != 0) return pq[k].pop_front();
    e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, lw[k]);
    if (v) begin
      lw[k] = d;
      pq[k].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, d));
      for (int i = 0; i < 4; i++)
        pq[k].push_back(mk(1'b0, 1'b1, 1'b1, dr ? d[i] : d[3-i], 1'b0,
                           dr ? 2'b01 : 2'b10, d));
      for (int g = 0; g < gap; g++)
        pq[k].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, d));
      pq[k].push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, d));
    end
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      pq[k].delete();
      lw[k] = 4'h0;
    end
  endfunction

  task automatic test_reset;
    obs_t e;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (o1 !== obs_t'(0)) begin bad++; $display("FAIL reset_g1 got=%h exp=%h", o1, obs_t'(0)); end
    total++;
    if (o0 !== obs_t'(0)) begin bad++; $display("FAIL reset_g0 got=%h exp=%h", o0, obs_t'(0)); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    e = model_step(1, 1, v1, d1, dr1);
    total++;
    if (o1 !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", o1, e); end
  endtask

  task automatic test_msb_first;
    obs_t e;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      v1 = (c == 0); d1 = (c == 0) ? 4'hA : 4'($urandom); dr1 = (c == 0) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL msb_first cyc=%0d got=%h exp=%h", c, o1, e); end
    end
  endtask

  task automatic test_lsb_first;
    obs_t e;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      v1 = (c == 0); d1 = (c == 0) ? 4'hA : 4'($urandom); dr1 = (c == 0) ? 1'b1 : 1'($urandom);
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL lsb_first cyc=%0d got=%h exp=%h", c, o1, e); end
    end
    total++;
    if (sr1 !== 4'h0) begin bad++; $display("FAIL lsb_sr_final got=%h exp=0", sr1); end
  endtask

  task automatic test_back_to_back;
    obs_t e;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      v1 = (c <= 8); d1 = (c == 0) ? 4'h3 : 4'hC; dr1 = 1'b0;
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, o1, e); end
    end
  endtask

  task automatic test_ignore_inputs;
    obs_t e;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin v1 = 1'b1; d1 = 4'h9; dr1 = 1'b0; end
      else if (c < 8) begin v1 = 1'($urandom); d1 = 4'($urandom); dr1 = 1'($urandom); end
      else begin v1 = 1'b0; end
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL ignore_inputs cyc=%0d got=%h exp=%h", c, o1, e); end
    end
  endtask

  task automatic test_reset_mid_word;
    obs_t e;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      v1 = (c == 0); d1 = 4'hA; dr1 = 1'b0;
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", c, o1, e); end
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if (o1 !== obs_t'(0)) begin bad++; $display("FAIL abort_outputs got=%h exp=%h", o1, obs_t'(0)); end
    model_reset();
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if (c == 0) rst = 1'b1;
      v1 = (c == 0); d1 = 4'h5; dr1 = 1'b0;
      @(negedge clk);
      e = model_step(1, 1, v1, d1, dr1);
      total++;
      if (o1 !== e) begin bad++; $display("FAIL abort_post cyc=%0d got=%h exp=%h", c, o1, e); end
    end
  endtask

  task automatic test_gap0;
    obs_t e;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      v0 = (c == 0); d0 = 4'hF; dr0 = 1'b0;
      @(negedge clk);
      e = model_step(0, 0, v0, d0, dr0);
      total++;
      if (o0 !== e) begin bad++; $display("FAIL gap0 cyc=%0d got=%h exp=%h", c, o0, e); end
    end
  endtask

  task automatic test_random;
    obs_t e1, e0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      v1 = (c < 390) ? 1'($urandom) : 1'b0; d1 = 4'($urandom); dr1 = 1'($urandom);
      v0 = (c < 390) ? 1'($urandom) : 1'b0; d0 = 4'($urandom); dr0 = 1'($urandom);
      @(negedge clk);
      e1 = model_step(1, 1, v1, d1, dr1);
      e0 = model_step(0, 0, v0, d0, dr0);
      total++;
      if (o1 !== e1) begin bad++; $display("FAIL random_g1 cyc=%0d got=%h exp=%h", c, o1, e1); end
      total++;
      if (o0 !== e0) begin bad++; $display("FAIL random_g0 cyc=%0d got=%h exp=%h", c, o0, e0); end
    end
  endtask

  initial begin
    rst = 1'b0;
    v1 = 1'b0; d1 = 4'h0; dr1 = 1'b0;
    v0 = 1'b0; d0 = 4'h0; dr0 = 1'b0;
    test_reset;
    test_msb_first;
    test_lsb_first;
    test_back_to_back;
    test_ignore_inputs;
    test_reset_mid_word;
    test_gap0;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
